clk_src_multi: RTL and testbench

Parametrised multi-channel successor to the single enable-started clock source. It is synthesizable and derives NUM_CH independent divided clocks from one reference clock.
- Each channel has its own enable, programmable half-period and programmable startup delay.
- Stop is glitch-free: a channel always parks at its initial level.
- Used as the on-chip stimulus/strobe generator for downstream blocks in place of free-running behavioural sources.

---
 rtl/clk_src_multi_pkg.sv | 18 +
 rtl/clk_src_ch.sv | 141 ++++++++++++++
 rtl/clk_src_multi.sv | 44 ++++
 tb/tb_clk_src_multi.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_src_multi_pkg.sv
// Shared types for the multi-channel divided clock source.
package clk_src_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RUN   = 2'd2,
    ST_STOP  = 2'd3
  } ch_state_e;

  // A programmed half-period of zero would never reach a toggle boundary, so it is clamped to this.
  localparam int unsigned MIN_HALF_PER = 1;

  function automatic logic state_is_active(input ch_state_e s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/clk_src_ch.sv
// One channel of clk_src_multi: start/stop FSM, half-period shadow, down-counter.
// Optional rising-edge counter when CLK_SRC_MULTI_EDGE_CNT_EN is defined.
module clk_src_ch
  import clk_src_multi_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter logic        INIT_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] half_per,
  input  logic [CNT_W-1:0] delay,
  output logic             clk_out,
  output logic             active,
  output logic [1:0]       state_dbg
`ifdef CLK_SRC_MULTI_EDGE_CNT_EN
  ,
  output logic [CNT_W-1:0] edge_cnt
`endif
);

  ch_state_e        state;
  ch_state_e        next_state;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] hp_q;
  logic [CNT_W-1:0] hp_d;
  logic [CNT_W-1:0] hp_clamped;
  logic             clk_d;
  logic             boundary;

  assign hp_clamped = (half_per == '0) ? CNT_W'(MIN_HALF_PER) : half_per;
  // The counter is reloaded with values >= 1 only, so reaching 1 marks the last cycle of a phase.
  assign boundary   = (cnt_q == CNT_W'(1));
  assign state_dbg  = state;

  always_comb begin
    next_state = state;
    cnt_d      = cnt_q;
    hp_d       = hp_q;
    clk_d      = clk_out;
    case (state)
      ST_IDLE: begin
        if (en) begin
          hp_d = hp_clamped;
          if (delay != '0) begin
            next_state = ST_DELAY;
            cnt_d      = delay;
          end else begin
            next_state = ST_RUN;
            cnt_d      = hp_clamped;
          end
        end
      end
      ST_DELAY: begin
        if (!en) begin
          next_state = ST_IDLE;
          cnt_d      = '0;
        end else if (boundary) begin
          next_state = ST_RUN;
          cnt_d      = hp_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!en && (clk_out == INIT_VAL)) begin
          next_state = ST_IDLE;
          cnt_d      = '0;
        end else if (boundary) begin
          clk_d = ~clk_out;
          cnt_d = hp_q;
          // Disabled on a boundary while away from the idle level: this toggle parks it.
          if (!en) begin
            next_state = ST_IDLE;
            cnt_d      = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (!en) next_state = ST_STOP;
        end
      end
      ST_STOP: begin
        if (boundary) begin
          clk_d      = INIT_VAL;
          next_state = ST_IDLE;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        next_state = ST_IDLE;
        cnt_d      = '0;
        clk_d      = INIT_VAL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt_q   <= '0;
      hp_q    <= '0;
      clk_out <= INIT_VAL;
      active  <= 1'b0;
    end else begin
      state   <= next_state;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      clk_out <= clk_d;
      active  <= state_is_active(next_state);
    end
  end

`ifdef CLK_SRC_MULTI_EDGE_CNT_EN
  logic             start;
  logic [CNT_W-1:0] edge_cnt_d;

  assign start = (state == ST_IDLE) && en;

  always_comb begin
    edge_cnt_d = edge_cnt;
    if (start) begin
      edge_cnt_d = '0;
    end else if (!clk_out && clk_d) begin
      edge_cnt_d = edge_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt_d;
    end
  end
`endif

endmodule

// File: rtl/clk_src_multi.sv
// NUM_CH independent divided clocks from one reference clock; channels are sliced off packed buses.
// Define CLK_SRC_MULTI_EDGE_CNT_EN to add the per-channel edge_cnt output.
module clk_src_multi
  import clk_src_multi_pkg::*;
#(
  parameter int unsigned       NUM_CH   = 4,
  parameter int unsigned       CNT_W    = 16,
  parameter logic [NUM_CH-1:0] INIT_VAL = {NUM_CH{1'b0}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*CNT_W-1:0] half_per,
  input  logic [NUM_CH*CNT_W-1:0] delay,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       active,
  output logic [2*NUM_CH-1:0]     ch_state
`ifdef CLK_SRC_MULTI_EDGE_CNT_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] edge_cnt
`endif
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_src_ch #(
      .CNT_W    (CNT_W),
      .INIT_VAL (INIT_VAL[i])
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en[i]),
      .half_per  (half_per[i*CNT_W +: CNT_W]),
      .delay     (delay[i*CNT_W +: CNT_W]),
      .clk_out   (clk_out[i]),
      .active    (active[i]),
      .state_dbg (ch_state[2*i +: 2])
`ifdef CLK_SRC_MULTI_EDGE_CNT_EN
      ,
      .edge_cnt  (edge_cnt[i*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_clk_src_multi.sv
// Scoreboard bench for clk_src_multi: expected output transitions are queued with their edge number.
module tb_clk_src_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam logic [NUM_CH-1:0] INIT_VAL = 4'b1000;

  localparam logic [7:0] P_CLK   = 8'd0;
  localparam logic [7:0] P_ACT   = 8'd1;
  localparam logic [7:0] P_STATE = 8'd2;
  localparam logic [7:0] P_ECNT  = 8'd3;
  localparam logic [7:0] P_ECNT0 = 8'd4;
  localparam logic [7:0] P_QSIZE = 8'd5;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]       en = '0;
  logic [NUM_CH*CNT_W-1:0] half_per = '0;
  logic [NUM_CH*CNT_W-1:0] delay = '0;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       active;
  logic [2*NUM_CH-1:0]     ch_state;
`ifdef CLK_SRC_MULTI_EDGE_CNT_EN
  logic [NUM_CH*CNT_W-1:0] edge_cnt;
`endif

  clk_src_multi #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .INIT_VAL (INIT_VAL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .half_per (half_per),
    .delay    (delay),
    .clk_out  (clk_out),
    .active   (active),
    .ch_state (ch_state)
`ifdef CLK_SRC_MULTI_EDGE_CNT_EN
    ,
    .edge_cnt (edge_cnt)
`endif
  );

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // scoreboard state
  logic [23:0] exp_q[$];
  logic [71:0] probe_q[$];
  int          checks = 0;
  int          failures = 0;
  logic        mon_en = 1'b0;
  logic [NUM_CH-1:0] prev_clk;
  logic [NUM_CH-1:0] prev_act;
  logic [23:0] got;
  logic [23:0] want;
  logic [71:0] pr;
  logic [63:0] obs;
  logic        cur;
  logic        prv;

  function automatic string ev_str(input logic [23:0] ev);
    return $sformatf("edge%0d/ch%0d/%s=%0d", ev[23:4], ev[3:2], ev[1] ? "active" : "clk_out", ev[0]);
  endfunction

  function automatic string probe_name(input logic [7:0] k);
    case (k)
      P_CLK:   return "clk_out";
      P_ACT:   return "active";
      P_STATE: return "ch_state";
      P_ECNT:  return "edge_cnt_all";
      P_ECNT0: return "edge_cnt_ch0";
      default: return "pending_events";
    endcase
  endfunction

  // driver tasks
  task automatic wait_to(input int n);
    while (edge_n < n) @(negedge clk);
  endtask

  task automatic cfg(input int ch, input int h, input int d);
    half_per[ch*CNT_W +: CNT_W] = CNT_W'(h);
    delay[ch*CNT_W +: CNT_W]    = CNT_W'(d);
  endtask

  task automatic exp_ev(input int e, input int ch, input int sig, input int v);
    exp_q.push_back({20'(e), 2'(ch), 1'(sig), 1'(v)});
  endtask

  task automatic probe(input logic [7:0] kind, input logic [63:0] val);
    probe_q.push_back({kind, val});
  endtask

  // monitor: every transition of clk_out/active must match the head of exp_q
  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int s = 0; s < 2; s++) begin
          cur = (s == 0) ? clk_out[c] : active[c];
          prv = (s == 0) ? prev_clk[c] : prev_act[c];
          if (cur !== prv) begin
            got = {20'(edge_n), 2'(c), (s == 1), cur};
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL event actual=%s required=none", ev_str(got));
            end else begin
              want = exp_q.pop_front();
              if (got !== want) begin
                failures++;
                $display("FAIL event actual=%s required=%s", ev_str(got), ev_str(want));
              end
            end
          end
        end
      end
      while (probe_q.size() != 0) begin
        pr = probe_q.pop_front();
        case (pr[71:64])
          P_CLK:   obs = 64'(clk_out);
          P_ACT:   obs = 64'(active);
          P_STATE: obs = 64'(ch_state);
`ifdef CLK_SRC_MULTI_EDGE_CNT_EN
          P_ECNT:  obs = 64'(edge_cnt);
          P_ECNT0: obs = 64'(edge_cnt[CNT_W-1:0]);
`endif
          default: obs = 64'(exp_q.size());
        endcase
        checks++;
        if (obs !== pr[63:0]) begin
          failures++;
          $display("FAIL %s actual=%0h required=%0h", probe_name(pr[71:64]), obs, pr[63:0]);
        end
      end
    end
    prev_clk <= clk_out;
    prev_act <= active;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // stimulus
  initial begin
    int e0;
    int e1;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    probe(P_CLK, 64'(INIT_VAL));
    probe(P_ACT, 64'd0);
    probe(P_STATE, 64'd0);
`ifdef CLK_SRC_MULTI_EDGE_CNT_EN
    probe(P_ECNT, 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // ch0 H=3 D=2, mid-run half_per change ignored
    wait_to(edge_n + 2);
    cfg(0, 3, 2); en[0] = 1'b1; e0 = edge_n + 1;
    exp_ev(e0, 0, 1, 1);
    exp_ev(e0 + 5, 0, 0, 1);  exp_ev(e0 + 8, 0, 0, 0);
    exp_ev(e0 + 11, 0, 0, 1); exp_ev(e0 + 14, 0, 0, 0);
    exp_ev(e0 + 15, 0, 1, 0);
    wait_to(e0 + 3); cfg(0, 7, 1);
    wait_to(e0 + 14); en[0] = 1'b0;
    wait_to(e0 + 18);

    // ch1 H=0 D=0 behaves as H=1; disable on a boundary at idle level
    cfg(1, 0, 0); en[1] = 1'b1; e0 = edge_n + 1;
    exp_ev(e0, 1, 1, 1);
    exp_ev(e0 + 1, 1, 0, 1); exp_ev(e0 + 2, 1, 0, 0);
    exp_ev(e0 + 3, 1, 0, 1); exp_ev(e0 + 4, 1, 0, 0);
    exp_ev(e0 + 5, 1, 1, 0);
    wait_to(e0 + 4); en[1] = 1'b0;
    wait_to(e0 + 8);

    // ch0 H=4 stop while high, en re-asserted during STOP, restart with H=2 D=1
    cfg(0, 4, 0); en[0] = 1'b1; e0 = edge_n + 1;
    exp_ev(e0, 0, 1, 1);
    exp_ev(e0 + 4, 0, 0, 1);
    exp_ev(e0 + 8, 0, 0, 0);  exp_ev(e0 + 8, 0, 1, 0);
    exp_ev(e0 + 9, 0, 1, 1);
    exp_ev(e0 + 12, 0, 0, 1); exp_ev(e0 + 14, 0, 0, 0);
    exp_ev(e0 + 15, 0, 1, 0);
    wait_to(e0 + 4); en[0] = 1'b0;
    wait_to(e0 + 6); en[0] = 1'b1; cfg(0, 2, 1);
    wait_to(e0 + 14); en[0] = 1'b0;
    wait_to(e0 + 18);

    // ch2 aborted during DELAY: no toggle
    cfg(2, 3, 5); en[2] = 1'b1; e0 = edge_n + 1;
    exp_ev(e0, 2, 1, 1);
    exp_ev(e0 + 2, 2, 1, 0);
    wait_to(e0 + 1); en[2] = 1'b0;
    wait_to(e0 + 12);

    // ch3 idles high: stop from low finishes the half-period and parks high
    cfg(3, 2, 1); en[3] = 1'b1; e0 = edge_n + 1;
    exp_ev(e0, 3, 1, 1);
    exp_ev(e0 + 3, 3, 0, 0); exp_ev(e0 + 5, 3, 0, 1); exp_ev(e0 + 7, 3, 0, 0);
    exp_ev(e0 + 9, 3, 0, 1); exp_ev(e0 + 9, 3, 1, 0);
    wait_to(e0 + 7); en[3] = 1'b0;
    wait_to(e0 + 12);

    // ch1 disabled exactly on the falling boundary: parks on that edge
    cfg(1, 2, 0); en[1] = 1'b1; e0 = edge_n + 1;
    exp_ev(e0, 1, 1, 1);
    exp_ev(e0 + 2, 1, 0, 1);
    exp_ev(e0 + 4, 1, 0, 0); exp_ev(e0 + 4, 1, 1, 0);
    wait_to(e0 + 3); en[1] = 1'b0;
    wait_to(e0 + 8);

    // all channels together, async reset mid-run, restart with en held
    cfg(0, 2, 0); cfg(1, 1, 1); cfg(2, 3, 2); cfg(3, 2, 0);
    en = 4'hF; e0 = edge_n + 1; e1 = e0 + 10;
    for (int c = 0; c < NUM_CH; c++) exp_ev(e0, c, 1, 1);
    exp_ev(e0 + 2, 0, 0, 1); exp_ev(e0 + 2, 1, 0, 1); exp_ev(e0 + 2, 3, 0, 0);
    exp_ev(e0 + 3, 1, 0, 0);
    exp_ev(e0 + 4, 0, 0, 0); exp_ev(e0 + 4, 1, 0, 1); exp_ev(e0 + 4, 3, 0, 1);
    exp_ev(e0 + 5, 1, 0, 0); exp_ev(e0 + 5, 2, 0, 1);
    exp_ev(e0 + 6, 0, 0, 1); exp_ev(e0 + 6, 1, 0, 1); exp_ev(e0 + 6, 3, 0, 0);
    exp_ev(e0 + 7, 0, 0, 0); exp_ev(e0 + 7, 0, 1, 0);
    exp_ev(e0 + 7, 1, 0, 0); exp_ev(e0 + 7, 1, 1, 0);
    exp_ev(e0 + 7, 2, 0, 0); exp_ev(e0 + 7, 2, 1, 0);
    exp_ev(e0 + 7, 3, 0, 1); exp_ev(e0 + 7, 3, 1, 0);
    for (int c = 0; c < NUM_CH; c++) exp_ev(e1, c, 1, 1);
    exp_ev(e1 + 2, 0, 0, 1); exp_ev(e1 + 2, 1, 0, 1); exp_ev(e1 + 2, 3, 0, 0);
    exp_ev(e1 + 3, 1, 0, 0);
    exp_ev(e1 + 4, 0, 0, 0); exp_ev(e1 + 4, 1, 0, 1); exp_ev(e1 + 4, 3, 0, 1);
    exp_ev(e1 + 5, 1, 0, 0); exp_ev(e1 + 5, 2, 0, 1);
    exp_ev(e1 + 6, 0, 1, 0); exp_ev(e1 + 6, 1, 1, 0); exp_ev(e1 + 6, 3, 1, 0);
    exp_ev(e1 + 8, 2, 0, 0); exp_ev(e1 + 8, 2, 1, 0);
    wait_to(e0 + 6);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    probe(P_CLK, 64'(INIT_VAL));
    probe(P_ACT, 64'd0);
    probe(P_STATE, 64'd0);
`ifdef CLK_SRC_MULTI_EDGE_CNT_EN
    probe(P_ECNT, 64'd0);
`endif
    wait_to(e0 + 9); rst = 1'b0;
    wait_to(e1 + 5); en = '0;
    wait_to(e1 + 12);

    // ch0 H=2: ten full periods
    cfg(0, 2, 0); en[0] = 1'b1; e0 = edge_n + 1;
    exp_ev(e0, 0, 1, 1);
    for (int k = 0; k < 10; k++) begin
      exp_ev(e0 + 2 + 4 * k, 0, 0, 1);
      exp_ev(e0 + 4 + 4 * k, 0, 0, 0);
    end
    exp_ev(e0 + 41, 0, 1, 0);
    wait_to(e0 + 40); en[0] = 1'b0;
    wait_to(e0 + 43);
    @(posedge clk);
    #1;
`ifdef CLK_SRC_MULTI_EDGE_CNT_EN
    probe(P_ECNT0, 64'd10);
`endif
    wait_to(edge_n + 1);

    // ch0 H=1: seventeen rises, counter cleared on restart
    cfg(0, 1, 0); en[0] = 1'b1; e0 = edge_n + 1;
    exp_ev(e0, 0, 1, 1);
    for (int k = 0; k < 17; k++) begin
      exp_ev(e0 + 1 + 2 * k, 0, 0, 1);
      exp_ev(e0 + 2 + 2 * k, 0, 0, 0);
    end
    exp_ev(e0 + 35, 0, 1, 0);
    @(posedge clk);
    #1;
`ifdef CLK_SRC_MULTI_EDGE_CNT_EN
    probe(P_ECNT0, 64'd0);
`endif
    wait_to(e0 + 34); en[0] = 1'b0;
    wait_to(e0 + 37);
    @(posedge clk);
    #1;
`ifdef CLK_SRC_MULTI_EDGE_CNT_EN
    probe(P_ECNT0, 64'(17 % (1 << CNT_W)));
`endif
    probe(P_STATE, 64'd0);
    probe(P_QSIZE, 64'd0);
    @(negedge clk);
    #1;

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
